// File: rtl/ser_frame_tx.sv
// rtl/ser_frame_tx.sv - clk_en-paced serial frame transmitter (start pattern + MSB-first payload)
`timescale 1ns/1ps
module ser_frame_tx #(
  parameter int                    DATA_W    = 8,
  parameter int                    START_W   = 4,
  parameter logic [START_W-1:0]    START_PAT = 4'b1101,
  parameter int                    GAP_BITS  = 2,
  parameter int                    CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              ser_out,
  output logic              ser_out_valid,
  output logic              tx_done,
  output logic [CNT_W-1:0]  cnt_out
);

  localparam int FRAME_W  = START_W + DATA_W;
  localparam int GAP_CW   = (GAP_BITS > 1) ? $clog2(GAP_BITS + 1) : 1;
  localparam int GAP_LAST = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;
  localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_W);
  localparam logic [GAP_CW-1:0] GAP_END   = GAP_CW'(GAP_LAST);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t              r_state;
  logic [FRAME_W-1:0]  r_shift;
  logic [CNT_W-1:0]    r_cnt;
  logic [GAP_CW-1:0]   r_gap;
  logic                r_ser;
  logic                r_valid;
  logic                r_done;
  logic                r_ready;

  // Frame sequencer: accept a load in IDLE, shift out one bit per strobe, then idle for GAP_BITS strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_ser   <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ser   <= 1'b0;
          r_valid <= 1'b0;
          if (load) begin
            r_shift <= {START_PAT, data_in};
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (clk_en) begin
            if (r_cnt == FRAME_CNT) begin
              // Last data bit's period ends here; the line drops back to idle level
              r_ser   <= 1'b0;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_gap   <= '0;
              if (GAP_BITS == 0) begin
                r_cnt   <= '0;
                r_ready <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_state <= S_GAP;
              end
            end else begin
              r_ser   <= r_shift[FRAME_W-1];
              r_valid <= 1'b1;
              r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
              r_cnt   <= r_cnt + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (clk_en) begin
            if (r_gap == GAP_END) begin
              r_cnt   <= '0;
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_cnt   <= '0;
          r_ser   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ready         = r_ready;
  assign ser_out       = r_ser;
  assign ser_out_valid = r_valid;
  assign tx_done       = r_done;
  assign cnt_out       = r_cnt;

endmodule

// File: tb/tb_ser_frame_tx.sv
// tb/tb_ser_frame_tx.sv - directed self-checking bench for ser_frame_tx
`timescale 1ns/1ps
module tb_ser_frame_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        load;
  logic [7:0]  data_in;
  logic        ready;
  logic        ser_out;
  logic        ser_out_valid;
  logic        tx_done;
  logic [3:0]  cnt_out;

  int errors = 0;
  int checks = 0;
  logic [11:0] frame;
  logic [11:0] frame2;
  logic        exp_v;
  logic        exp_s;

  ser_frame_tx #(
    .DATA_W   (8),
    .START_W  (4),
    .START_PAT(4'b1101),
    .GAP_BITS (2),
    .CNT_W    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .load         (load),
    .data_in      (data_in),
    .ready        (ready),
    .ser_out      (ser_out),
    .ser_out_valid(ser_out_valid),
    .tx_done      (tx_done),
    .cnt_out      (cnt_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en);
    clk_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    step(1'b0);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    clk_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b0; load = 1'b0; data_in = 8'h00;
    step(1'b0);
    step(1'b0);
    rst = 1'b0;
    chk("rst_ready", ready, 1);
    chk("rst_ser", ser_out, 0);
    chk("rst_valid", ser_out_valid, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_cnt", cnt_out, 0);

    // Basic frame A5 with strobe every 4th clk, busy load of FF mid-frame
    frame = 12'hDA5;
    data_in = 8'hA5; load = 1'b1;
    step(1'b0);
    load = 1'b0;
    chk("acc_ready", ready, 0);
    chk("acc_valid", ser_out_valid, 0);
    chk("acc_cnt", cnt_out, 0);
    for (int i = 0; i < 12; i++) begin
      if (i == 5) begin load = 1'b1; data_in = 8'hFF; end
      strobe();
      load = 1'b0;
      chk("basic_ser", ser_out, frame[11-i]);
      chk("basic_valid", ser_out_valid, 1);
      chk("basic_cnt", cnt_out, i + 1);
      chk("basic_nodone", tx_done, 0);
    end
    strobe();
    chk("basic_done", tx_done, 1);
    chk("basic_end_valid", ser_out_valid, 0);
    chk("basic_end_ser", ser_out, 0);
    chk("basic_end_cnt", cnt_out, 12);
    step(1'b0);
    chk("basic_done_pulse", tx_done, 0);
    strobe();
    chk("gap1_ready", ready, 0);
    chk("gap1_cnt", cnt_out, 12);
    strobe();
    chk("gap2_ready", ready, 1);
    chk("gap2_cnt", cnt_out, 0);
    strobe();
    strobe();
    chk("no_second_valid", ser_out_valid, 0);
    chk("no_second_ready", ready, 1);

    // Continuous strobe, load held high: 3C then C3 back-to-back
    frame  = 12'hD3C;
    frame2 = 12'hDC3;
    data_in = 8'h3C; load = 1'b1;
    step(1'b1);
    chk("cont_acc_ready", ready, 0);
    chk("cont_acc_valid", ser_out_valid, 0);
    data_in = 8'hC3;
    for (int k = 1; k <= 28; k++) begin
      step(1'b1);
      exp_v = (k <= 12) || (k >= 17);
      exp_s = (k <= 12) ? frame[12-k] : ((k >= 17) ? frame2[28-k] : 1'b0);
      chk("cont_valid", ser_out_valid, exp_v);
      chk("cont_ser", ser_out, exp_s);
      chk("cont_ready", ready, (k == 15));
      chk("cont_done", tx_done, (k == 13));
    end
    load = 1'b0;
    step(1'b1);
    chk("cont_done2", tx_done, 1);
    step(1'b1);
    step(1'b1);
    chk("cont_idle_ready", ready, 1);
    chk("cont_idle_cnt", cnt_out, 0);
    step(1'b1);
    chk("cont_idle_valid", ser_out_valid, 0);

    // Load coincident with strobe in IDLE, then reset after 5 bits
    frame = 12'hD80;
    data_in = 8'h80; load = 1'b1;
    step(1'b1);
    load = 1'b0;
    chk("coin_ready", ready, 0);
    chk("coin_valid", ser_out_valid, 0);
    chk("coin_cnt", cnt_out, 0);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    chk("coin_first_ser", ser_out, 1);
    chk("coin_first_valid", ser_out_valid, 1);
    chk("coin_first_cnt", cnt_out, 1);
    for (int i = 1; i < 5; i++) begin
      step(1'b1);
      chk("coin_ser", ser_out, frame[11-i]);
      chk("coin_cnt", cnt_out, i + 1);
    end
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    chk("mid_rst_ser", ser_out, 0);
    chk("mid_rst_valid", ser_out_valid, 0);
    chk("mid_rst_cnt", cnt_out, 0);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_done", tx_done, 0);

    // Full frame 5A with a 20-clk strobe stall after bit 6
    frame = 12'hD5A;
    data_in = 8'h5A; load = 1'b1;
    step(1'b0);
    load = 1'b0; data_in = 8'h00;
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      chk("stall_pre_ser", ser_out, frame[11-i]);
      chk("stall_pre_cnt", cnt_out, i + 1);
    end
    for (int j = 0; j < 20; j++) begin
      step(1'b0);
      chk("stall_ser", ser_out, frame[6]);
      chk("stall_valid", ser_out_valid, 1);
      chk("stall_cnt", cnt_out, 6);
    end
    for (int i = 6; i < 12; i++) begin
      step(1'b1);
      chk("stall_post_ser", ser_out, frame[11-i]);
      chk("stall_post_valid", ser_out_valid, 1);
      chk("stall_post_cnt", cnt_out, i + 1);
    end
    step(1'b1);
    chk("stall_done", tx_done, 1);
    chk("stall_end_cnt", cnt_out, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
